// File: rtl/xor_arb_pkg.sv
// rtl/xor_arb_pkg.sv - shared types, widths and round-robin pick helper for the XOR share arbiter
package xor_arb_pkg;

    localparam int DATA_W  = 8;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // First set bit of valid scanning ptr, ptr+1, ... modulo nreq; ptr when none is set.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int nreq);
        int win;
        int idx;
        logic found;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (ptr + k) % nreq;
            if (k < nreq && !found && valid[idx[2:0]]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/xor_i8_share_arbiter_if.sv
// rtl/xor_i8_share_arbiter_if.sv - request/response bundle between producers and the XOR share arbiter
interface xor_i8_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    import xor_arb_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [DATA_W*NREQ-1:0] req_a;
    logic [DATA_W*NREQ-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [DATA_W-1:0]      rsp_y;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y
    );

endinterface

// File: rtl/xor_i8_i8_i8.sv
// rtl/xor_i8_i8_i8.sv - shared 8-bit XOR datapath with LAT register stages
module xor_i8_i8_i8 #(
    parameter int LAT = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] y_o
);

    generate
        if (LAT == 0) begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i ^ rst_i;
            assign y_o = a_i ^ b_i;
        end else begin : g_pipe
            logic [7:0] pipe_q [LAT];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= a_i ^ b_i;
                    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign y_o = pipe_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/xor_i8_share_arbiter.sv
// rtl/xor_i8_share_arbiter.sv - round-robin sharing of one XOR datapath among NREQ requesters
module xor_i8_share_arbiter
    import xor_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DP_LAT = 0,
    parameter int IDW    = $clog2(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    xor_i8_share_arbiter_if.slave bus,
    output logic                  busy
);

    state_e              state_q, state_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   dp_y;
    logic [IDW-1:0]      win;
    logic [NREQ-1:0]     grant;

    assign win = IDW'(rr_pick(MAX_REQ'(bus.req_valid), int'(ptr_q), NREQ));

    xor_i8_i8_i8 #(.LAT(DP_LAT)) dut (
        .clk_i (clock),
        .rst_i (~reset),
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .y_o   (dp_y)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        grant   = '0;
        case (state_q)
            ST_IDLE: begin
                // The winner is always a valid requester, so a grant is also a handshake.
                if (|bus.req_valid) begin
                    grant   = NREQ'(1) << win;
                    op_a_d  = bus.req_a[DATA_W*win +: DATA_W];
                    op_b_d  = bus.req_b[DATA_W*win +: DATA_W];
                    id_d    = win;
                    ptr_d   = IDW'((int'(win) + 1) % NREQ);
                    cnt_d   = 2'(DP_LAT);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    y_d     = dp_y;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grants are combinational, so they are masked while reset is held.
    assign bus.req_ready = reset ? grant : '0;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_y     = y_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_xor_i8_share_arbiter.sv
// tb/tb_xor_i8_share_arbiter.sv - scoreboard bench for the XOR share arbiter
module tb_xor_i8_share_arbiter;

    localparam int NREQ   = 4;
    localparam int DP_LAT = 2;
    localparam int IDW    = 2;

    typedef struct {
        int id;
        int y;
        int cyc;
    } exp_t;

    logic clock = 1'b0;
    logic rst_n = 1'b1;
    logic busy;

    exp_t     q[$];
    int       total = 0;
    int       bad   = 0;
    int       cyc   = 0;
    int       mptr  = 0;
    bit       hv [NREQ];
    bit [7:0] ha [NREQ];
    bit [7:0] hb [NREQ];
    bit       rr_v  = 1'b1;
    bit       rst_v = 1'b0;
    bit       prev_valid = 1'b0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    xor_i8_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    xor_i8_share_arbiter #(.NREQ(NREQ), .DP_LAT(DP_LAT)) dut (
        .clock (clock),
        .reset (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Round-robin rule: first valid index scanning from p with wrap.
    function automatic int model_pick(input bit [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic tick();
        bit [NREQ-1:0] v;
        int w;
        @(negedge clock);
        #1;
        rst_n = rst_v;
        if (!rst_v) begin
            q.delete();
            mptr = 0;
        end
        for (int i = 0; i < NREQ; i++) begin
            v[i] = hv[i];
            bus.req_a[8*i +: 8] = ha[i];
            bus.req_b[8*i +: 8] = hb[i];
        end
        bus.req_valid = v;
        bus.rsp_ready = rr_v;
        #1;
        if (!rst_v) begin
            chk("rst_req_ready", int'(bus.req_ready), 0);
            chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_rsp_y", int'(bus.rsp_y), 0);
            chk("rst_rsp_id", int'(bus.rsp_id), 0);
        end else begin
            chk("busy", int'(busy), int'(q.size() != 0));
            if (q.size() != 0) begin
                chk("ready_while_busy", int'(bus.req_ready), 0);
            end else begin
                w = model_pick(v, mptr);
                chk("grant", int'(bus.req_ready), (w < 0) ? 0 : (1 << w));
                if (w >= 0) begin
                    q.push_back('{w, int'(ha[w] ^ hb[w]), cyc});
                    mptr  = (w + 1) % NREQ;
                    hv[w] = 1'b0;
                end
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Response monitor: compares every presented result against the queue head.
    always begin
        @(negedge clock);
        #3;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else if (bus.rsp_valid) begin
            chk("rsp_expected", int'(q.size() != 0), 1);
            if (q.size() != 0) begin
                if (!prev_valid) chk("rsp_latency", cyc, q[0].cyc + 2 + DP_LAT);
                chk("rsp_id", int'(bus.rsp_id), q[0].id);
                chk("rsp_y", int'(bus.rsp_y), q[0].y);
                if (bus.rsp_ready) void'(q.pop_front());
            end
            prev_valid = 1'b1;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        int guard;
        for (int i = 0; i < NREQ; i++) begin
            hv[i] = 1'b0;
            ha[i] = 8'h00;
            hb[i] = 8'h00;
        end

        // reset, then idle with no requests
        rst_v = 1'b0;
        ticks(3);
        rst_v = 1'b1;
        ticks(3);

        // single requester
        hv[0] = 1'b1; ha[0] = 8'd3; hb[0] = 8'd12;
        ticks(10);

        // all four at once, held until granted
        for (int i = 0; i < NREQ; i++) begin
            hv[i] = 1'b1; ha[i] = 8'(i + 1); hb[i] = 8'hF0;
        end
        ticks(25);

        // fairness wrap: 3 alone, then 0 and 2 together
        hv[3] = 1'b1; ha[3] = 8'h5A; hb[3] = 8'hA5;
        ticks(8);
        hv[0] = 1'b1; ha[0] = 8'h11; hb[0] = 8'h22;
        hv[2] = 1'b1; ha[2] = 8'h33; hb[2] = 8'h44;
        ticks(15);

        // backpressure
        rr_v = 1'b0;
        hv[1] = 1'b1; ha[1] = 8'hFF; hb[1] = 8'h0F;
        ticks(10);
        rr_v = 1'b1;
        ticks(3);

        // reset during EXEC
        hv[2] = 1'b1; ha[2] = 8'($urandom); hb[2] = 8'($urandom);
        guard = 0;
        while (q.size() == 0 && guard < 10) begin
            tick();
            guard++;
        end
        chk("exec_grant_seen", int'(q.size()), 1);
        tick();
        rst_v = 1'b0;
        hv[1] = 1'b1; ha[1] = 8'h77; hb[1] = 8'h70;
        hv[3] = 1'b1; ha[3] = 8'h0C; hb[3] = 8'hC0;
        ticks(3);
        rst_v = 1'b1;
        ticks(12);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!hv[i] && $urandom_range(0, 3) == 0) begin
                    hv[i] = 1'b1;
                    ha[i] = 8'($urandom);
                    hb[i] = 8'($urandom);
                end else if (hv[i] && $urandom_range(0, 15) == 0) begin
                    hv[i] = 1'b0;
                end
            end
            rr_v = ($urandom_range(0, 3) != 0);
            tick();
        end

        // drain
        for (int i = 0; i < NREQ; i++) hv[i] = 1'b0;
        rr_v  = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 60) begin
            tick();
            guard++;
        end
        chk("drain_empty", int'(q.size()), 0);
        ticks(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
